// File: rtl/bytesub_shiftrow_en.sv
// bytesub_shiftrow_en
//   AES encrypt round stage that follows AddRoundKey. It reads the 16 state
//   bytes from the statemt dual-port RAM two at a time, applies SubBytes,
//   stores the results in a local 16-byte buffer, and then writes them back
//   in ShiftRows order.
//
//   Byte (row r, col c) lives at BASE_ADDR + 4c + r. Only bits [7:0] of a
//   RAM word carry state; written words are zero-extended.
//
//   Optional build macro: BYTESUB_SBOX_PIPE_EN adds a register after the
//   S-box lookup. CAP then lasts two cycles and the total latency is 19
//   cycles instead of 18. The written RAM contents are the same in both builds.
//
// Ports
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   ap_start                start request (ignored while busy, never queued)
//   ap_done, ap_ready       one-cycle completion pulses, both high in FIN
//   ap_idle                 high in IDLE
//   statemt_address0/1      RAM port 0/1 address
//   statemt_ce0/1, we0/1    RAM port 0/1 enable and write enable
//   statemt_d0/1            RAM port 0/1 write data
//   statemt_q0/1            RAM port 0/1 read data, valid one cycle after ce
module bytesub_shiftrow_en #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] statemt_address0,
  output logic              statemt_ce0,
  output logic              statemt_we0,
  output logic [DATA_W-1:0] statemt_d0,
  input  logic [DATA_W-1:0] statemt_q0,
  output logic [ADDR_W-1:0] statemt_address1,
  output logic              statemt_ce1,
  output logic              statemt_we1,
  output logic [DATA_W-1:0] statemt_d1,
  input  logic [DATA_W-1:0] statemt_q1
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIN} state_t;

  state_t     state, state_n;
  logic [2:0] k, k_n;          // pair counter in RD/WR, cycle counter in CAP
  logic [7:0] sbuf [16];       // SubBytes result, indexed by 4c + r

  // Destination offset {c, r} takes its byte from sbuf(r, (c + r) mod 4);
  // the 2-bit add wraps the column for free.
  function automatic logic [3:0] shift_src(input logic [3:0] off);
    return {off[3:2] + off[1:0], off[1:0]};
  endfunction

  // Read data of pair k-1 arrives while RD is at pair k. In CAP the counter
  // has wrapped to 0, so k-1 names pair 7.
  logic       cap_en;
  logic [2:0] cap_pair;
  assign cap_en   = (state == S_RD && k != 3'd0) || (state == S_CAP && k == 3'd0);
  assign cap_pair = k - 3'd1;

  // Upper data bits carry no state.
  logic unused_q;
  assign unused_q = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
      k     <= 3'd0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end

`ifdef BYTESUB_SBOX_PIPE_EN
  logic       pipe_en;
  logic [2:0] pipe_pair;
  logic [7:0] pipe_b0, pipe_b1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) pipe_en <= 1'b0;
    else           pipe_en <= cap_en;
  end

  always_ff @(posedge ap_clk) begin
    pipe_pair <= cap_pair;
    pipe_b0   <= SBOX[statemt_q0[7:0]];
    pipe_b1   <= SBOX[statemt_q1[7:0]];
    if (pipe_en) begin
      sbuf[{pipe_pair, 1'b0}] <= pipe_b0;
      sbuf[{pipe_pair, 1'b1}] <= pipe_b1;
    end
  end
`else
  // NOTE: the byte buffer has no reset; every entry is written in RD/CAP
  // before WR reads it, so a reset would only add muxes to the storage.
  always_ff @(posedge ap_clk) begin
    if (cap_en) begin
      sbuf[{cap_pair, 1'b0}] <= SBOX[statemt_q0[7:0]];
      sbuf[{cap_pair, 1'b1}] <= SBOX[statemt_q1[7:0]];
    end
  end
`endif

  // NOTE: every signal is given a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    k_n     = k;
    unique case (state)
      S_IDLE: if (ap_start) begin
        state_n = S_RD;
        k_n     = 3'd0;
      end
      S_RD: begin
        k_n = k + 3'd1;
        if (k == 3'd7) state_n = S_CAP;
      end
`ifdef BYTESUB_SBOX_PIPE_EN
      S_CAP: begin
        if (k == 3'd0) begin
          k_n = 3'd1;
        end else begin
          k_n     = 3'd0;
          state_n = S_WR;
        end
      end
`else
      S_CAP: begin
        k_n     = 3'd0;
        state_n = S_WR;
      end
`endif
      S_WR: begin
        k_n = k + 3'd1;
        if (k == 3'd7) state_n = S_FIN;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // drops the RAM enables in the same cycle.
  always_comb begin
    ap_idle          = (state == S_IDLE);
    ap_done          = (state == S_FIN);
    ap_ready         = (state == S_FIN);
    statemt_address0 = '0;
    statemt_address1 = '0;
    statemt_ce0      = 1'b0;
    statemt_ce1      = 1'b0;
    statemt_we0      = 1'b0;
    statemt_we1      = 1'b0;
    statemt_d0       = '0;
    statemt_d1       = '0;
    if (state == S_RD || state == S_WR) begin
      statemt_address0 = BASE + ADDR_W'({k, 1'b0});
      statemt_address1 = BASE + ADDR_W'({k, 1'b1});
      statemt_ce0      = 1'b1;
      statemt_ce1      = 1'b1;
    end
    if (state == S_WR) begin
      statemt_we0 = 1'b1;
      statemt_we1 = 1'b1;
      statemt_d0  = DATA_W'(sbuf[shift_src({k, 1'b0})]);
      statemt_d1  = DATA_W'(sbuf[shift_src({k, 1'b1})]);
    end
  end

endmodule

// File: tb/tb_bytesub_shiftrow_en.sv
// Testbench for bytesub_shiftrow_en: a behavioural dual-port RAM, directed
// runs with hand-computed expected images pushed to a scoreboard, and a
// monitor that checks the RAM image and the cycle number at every ap_done.
module tb_bytesub_shiftrow_en;

`ifdef BYTESUB_SBOX_PIPE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 18;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_idle, ap_ready;
  logic [4:0]  addr0, addr1;
  logic        ce0, ce1, we0, we1;
  logic [31:0] d0, d1;
  logic [31:0] q0 = '0, q1 = '0;

  bytesub_shiftrow_en #(.ADDR_W(5), .DATA_W(32), .BASE_ADDR(0)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .statemt_address0(addr0), .statemt_ce0(ce0), .statemt_we0(we0),
    .statemt_d0(d0), .statemt_q0(q0),
    .statemt_address1(addr1), .statemt_ce1(ce1), .statemt_we1(we1),
    .statemt_d1(d1), .statemt_q1(q1)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Behavioural RAM with one-cycle read latency on both ports.
  logic [31:0] mem [32];
  always @(posedge ap_clk) begin
    if (ce0 && we0) mem[addr0] <= d0;
    if (ce1 && we1) mem[addr1] <= d1;
    if (ce0 && !we0) q0 <= mem[addr0];
    if (ce1 && !we1) q1 <= mem[addr1];
  end

  int bad_acc = 0;
  always @(negedge ap_clk)
    if ((ce0 && addr0 > 5'd15) || (ce1 && addr1 > 5'd15)) bad_acc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [31:0]       cyc;
    logic [15:0][31:0] img;
  } exp_t;
  exp_t sb_q [$];

  // Monitor: every ap_done must match the oldest expectation.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (ap_ready !== ap_done) check("ready_eq_done", 32'(ap_ready), 32'(ap_done));
      if (ap_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(ap_done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_cycle", 32'(cyc), e.cyc);
          for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), mem[i], e.img[i]);
        end
      end
    end
  end

  localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] ALL_00   = {16{8'h00}};
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_FB   = {16{8'hfb}};

  function automatic logic [15:0][31:0] img_from(input logic [127:0] v);
    logic [15:0][31:0] img;
    for (int i = 0; i < 16; i++) img[i] = {24'h0, v[127-8*i -: 8]};
    return img;
  endfunction

  task automatic load(input logic [127:0] v, input logic [23:0] upper);
    for (int i = 0; i < 16; i++) mem[i] = {upper, v[127-8*i -: 8]};
    for (int i = 16; i < 32; i++) mem[i] = 32'hdead_0000 + 32'(i);
  endtask

  task automatic push_exp(input int at, input logic [127:0] v);
    exp_t e;
    e.cyc = 32'(at);
    e.img = img_from(v);
    sb_q.push_back(e);
  endtask

  // One-cycle start pulse; t0 is the cycle in which the start is accepted.
  task automatic start_run(input logic [127:0] exp_v, output int t0);
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, exp_v);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 200 && !(sb_q.size() == 0 && ap_idle)) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    check({name, "_in_range"}, 32'(bad_acc), 32'd0);
    repeat (3) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    load(ALL_00, 24'h0);

    // Reset state.
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_done", 32'(ap_done), 32'd0);
    check("rst_ready", 32'(ap_ready), 32'd0);
    check("rst_ce_we", {28'd0, ce0, ce1, we0, we1}, 32'd0);
    check("rst_addr", {22'd0, addr0, addr1}, 32'd0);
    check("rst_data", d0 | d1, 32'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("idle_after_rst", 32'(ap_idle), 32'd1);

    // FIPS-197 round-1 vector.
    load(FIPS_IN, 24'h0);
    start_run(FIPS_OUT, t0);
    wait_idle("fips");

    // All zero words; ap_idle low through the whole run.
    load(ALL_00, 24'h0);
    start_run(ALL_63, t0);
    for (int j = 1; j <= LAT; j++) begin
      check($sformatf("busy_idle_c%0d", j), 32'(ap_idle), 32'd0);
      @(posedge ap_clk); #1;
    end
    check("idle_after_fin", 32'(ap_idle), 32'd1);
    wait_idle("zeros");

    // Upper data bits must be ignored.
    load(ALL_00, 24'hffffff);
    start_run(ALL_63, t0);
    wait_idle("upper_bits");

    // Second start pulse at cycle 5 is ignored.
    load(FIPS_IN, 24'h0);
    start_run(FIPS_OUT, t0);
    while (cyc < t0 + 5) begin
      @(posedge ap_clk); #1;
    end
    ap_start = 1'b1;
    check("busy_at_c5", 32'(ap_idle), 32'd0);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    wait_idle("start_while_busy");

    // Reset in the middle of WR, then a clean restart.
    load(FIPS_IN, 24'h0);
    start_run(FIPS_OUT, t0);
    while (cyc < t0 + 12) begin
      @(posedge ap_clk); #1;
    end
    check("pre_rst_we", {30'd0, we0, we1}, 32'd3);
    sb_q.delete();
    ap_rst_n = 1'b0;
    #1;
    check("midrst_ce_we", {28'd0, ce0, ce1, we0, we1}, 32'd0);
    check("midrst_idle", 32'(ap_idle), 32'd1);
    repeat (2) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b1;
    load(FIPS_IN, 24'h0);
    start_run(FIPS_OUT, t0);
    wait_idle("restart");

    // ap_start held high: back-to-back runs, 0x00 -> 0x63 -> 0xfb.
    load(ALL_00, 24'h0);
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, ALL_63);
    push_exp(t0 + 2 * LAT + 1, ALL_FB);
    while (cyc < t0 + LAT + 1) begin
      @(posedge ap_clk); #1;
    end
    check("idle_between_runs", 32'(ap_idle), 32'd1);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    check("second_accepted", 32'(ap_idle), 32'd0);
    wait_idle("held_start");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
